mips_div_unit: RTL and testbench
================================

# mips_div_unit

Multi-cycle 32-bit integer divider for the `div`/`divu` instructions. It runs a restoring radix-2 algorithm, one quotient bit per clock, and holds quotient (LO) and remainder (HI) stable until the next operation completes. Its outputs feed the HI/LO result inputs of the write-back select mux. The control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand and result width in bits; the counter width is `$clog2(WIDTH)+1`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `start`  in  1  request a division; sampled only in IDLE.
- `is_signed`  in  1  1 = `div` (two's complement), 0 = `divu`.
- `dividend`  in  WIDTH  rs operand; sampled with `start`.
- `divisor`  in  WIDTH  rt operand; sampled with `start`.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse when the results update.
- `quotient`  out  WIDTH  registered quotient, goes to LO.
- `remainder`  out  WIDTH  registered remainder, goes to HI.
- `div_by_zero`  out  1  registered flag; set when the last operation had divisor 0.

## Operation
- FSM states are IDLE, RUN and FIX. `busy` = (state != IDLE).
- **IDLE → RUN** on `start`:
  - latch `is_signed`, the divisor-zero flag, both operand signs, and the raw dividend;
  - latch |dividend| and |divisor|, where |x| = x when unsigned or non-negative, else (~x+1) truncated to WIDTH;
  - clear the partial remainder and the counter.
- **RUN**, once per cycle:
  - {rem, quo} shifts left one bit;
  - trial = rem − |divisor| at WIDTH+1 bits;
  - if the trial is non-negative, rem = trial and the quo LSB = 1;
  - the counter increments;
  - after the WIDTH-th step, move to FIX.
- **FIX → IDLE**:
  - if signed and the operand signs differ, negate the quotient;
  - if signed and the dividend is negative, negate the remainder;
  - register `quotient`, `remainder` and `div_by_zero`, and pulse `done`.
- Divide by zero is decided behaviour and keeps the same latency:
  - `quotient` = all ones;
  - `remainder` = raw dividend;
  - `div_by_zero` = 1.
- Signed overflow (0x80000000 / −1) needs no special case. Wrap arithmetic yields `quotient` 0x80000000 and `remainder` 0.
- `start` in RUN or FIX is ignored. No queueing.
- Outputs hold their values between completions. Operand changes after the `start` cycle have no effect.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE;
  - `busy`, `done` and `div_by_zero` = 0;
  - `quotient` and `remainder` = 0;
  - the counter and datapath registers are cleared, and the in-flight operation is discarded.
- Clock edges are numbered relative to the edge E0 that samples `start`:
  - E1..E32 perform the WIDTH iterations;
  - E33 is the FIX edge; it updates the outputs and raises `done`;
  - E34 clears `done`.
- Latency: results are valid and `done` = 1 in the cycle after E33. The unit is busy for 33 cycles (E0 to E33).
- `busy` falls at the same edge that raises `done`.
- Back-to-back: a `start` asserted during the `done` cycle is accepted at E34 (state is IDLE). That `done` pulse is still exactly one cycle.
- `done` never stays high for two consecutive cycles.

## Structure
- Package `mips_div_pkg` holds:
  - the `div_state_t` enum (IDLE, RUN, FIX);
  - `DIV_ZERO_QUOTIENT` (all ones).
- One combinational sub-module, `div_step`, is natural. Inputs: rem, quo, |divisor|. Outputs: the next rem and quo.
- The FSM, counter and sign fix-up stay in the top-level module.

## Test plan
- Unsigned 100 / 7, `start` for one cycle:
  - `busy` high for exactly 33 cycles;
  - `done` pulses once;
  - `quotient` = 14, `remainder` = 2, `div_by_zero` = 0.
- Signed −7 / 2 (0xFFFFFFF9 / 2): `quotient` = 0xFFFFFFFD, `remainder` = 0xFFFFFFFF. Signed 7 / −2: `quotient` = 0xFFFFFFFD, `remainder` = 1.
- Signed 0x80000000 / 0xFFFFFFFF: `quotient` = 0x80000000, `remainder` = 0. The same operands unsigned give `quotient` = 0, `remainder` = 0x80000000.
- Divide by zero, 5 / 0, both signed and unsigned: after 33 cycles, `quotient` = 0xFFFFFFFF, `remainder` = 5, `div_by_zero` = 1. The next valid divide clears the flag.
- Re-`start` mid-run and back-to-back:
  - re-`start` at cycle 10 with new operands is ignored; the first result is unchanged;
  - a `start` during the `done` cycle begins a second run, which completes 33 cycles later.
- Reset mid-run: drop `rst_n` at cycle 15 of a run, asynchronous to `clk`.
  - Immediately: `busy` = 0, outputs = 0, no `done`.
  - After release, a new 9 / 3 gives `quotient` 3, `remainder` 0.

Source files
------------

// File: rtl/mips_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_pkg
// Description : Shared types and constants for the MIPS div/divu unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage
`default_nettype wire

// File: rtl/mips_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_unit_if
// Description : Request/result bundle between the control unit and divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/mips_div_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring radix-2 iteration: shift, trial subtract, select.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;

    // Partial remainder is always below the divisor, so WIDTH+1 bits suffice.
    assign w_rem_sh = {rem, quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, dvsr};

    always_comb begin
        rem_next = w_rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            rem_next = w_trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule
`default_nettype wire

// File: rtl/mips_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_unit
// Description : Multi-cycle restoring divider for div/divu; HI/LO held stable.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    mips_div_unit_if.slave  div_if
);
    localparam int                CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] quo_q,       quo_d;
    logic [WIDTH-1:0] dvsr_q,      dvsr_d;
    logic [WIDTH-1:0] raw_a_q,     raw_a_d;
    logic             signed_q,    signed_d;
    logic             zero_q,      zero_d;
    logic             sign_a_q,    sign_a_d;
    logic             sign_b_q,    sign_b_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;
    logic             done_q,      done_d;

    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_neg_a;
    logic             w_neg_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvsr     (dvsr_q),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    assign w_neg_a = div_if.is_signed & div_if.dividend[WIDTH-1];
    assign w_neg_b = div_if.is_signed & div_if.divisor[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        raw_a_d     = raw_a_q;
        signed_d    = signed_q;
        zero_d      = zero_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    rem_d    = '0;
                    signed_d = div_if.is_signed;
                    zero_d   = (div_if.divisor == '0);
                    sign_a_d = div_if.dividend[WIDTH-1];
                    sign_b_d = div_if.divisor[WIDTH-1];
                    raw_a_d  = div_if.dividend;
                    quo_d    = w_neg_a ? (~div_if.dividend + 1'b1) : div_if.dividend;
                    dvsr_d   = w_neg_b ? (~div_if.divisor + 1'b1) : div_if.divisor;
                end
            end
            RUN: begin
                rem_d = w_rem_next;
                quo_d = w_quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = zero_q;
                // Zero divisor overrides the iteration result with fixed values.
                if (zero_q) begin
                    quotient_d  = DIV_ZERO_QUOTIENT;
                    remainder_d = raw_a_q;
                end else begin
                    quotient_d  = (signed_q && (sign_a_q ^ sign_b_q)) ? (~quo_q + 1'b1) : quo_q;
                    remainder_d = (signed_q && sign_a_q) ? (~rem_q + 1'b1) : rem_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            raw_a_q     <= '0;
            signed_q    <= 1'b0;
            zero_q      <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            raw_a_q     <= raw_a_d;
            signed_q    <= signed_d;
            zero_q      <= zero_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign div_if.busy        = (state_q != IDLE);
    assign div_if.done        = done_q;
    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.div_by_zero = dbz_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_div_unit
// Description : Directed self-checking bench for the div/divu unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_div_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mips_div_unit_if #(.WIDTH(32)) dif ();

    mips_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the next rising edge samples the request.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        dif.start     = 1'b1;
        dif.is_signed = s;
        dif.dividend  = a;
        dif.divisor   = b;
    endtask

    // Counts busy cycles; optionally fires a junk start at restart_at.
    task automatic wait_done(input string tag, input int restart_at,
                             input logic [31:0] exp_q, input logic [31:0] exp_r,
                             input logic exp_z);
        int cycles;
        int early_done;
        cycles     = 0;
        early_done = 0;
        @(negedge clk);
        dif.start = 1'b0;
        while (dif.busy && cycles < 100) begin
            cycles++;
            if (dif.done) early_done++;
            if (cycles == restart_at) begin
                dif.start     = 1'b1;
                dif.is_signed = 1'b0;
                dif.dividend  = 32'd1000;
                dif.divisor   = 32'd3;
            end else begin
                dif.start    = 1'b0;
                dif.dividend = 32'hDEAD_BEEF;
                dif.divisor  = 32'h0000_0011;
            end
            @(negedge clk);
        end
        dif.start = 1'b0;
        check_eq({tag, "_busy_cycles"}, 32'(cycles), 32'd33);
        check_eq({tag, "_early_done"},  32'(early_done), 32'd0);
        check_eq({tag, "_done"},        {31'd0, dif.done}, 32'd1);
        check_eq({tag, "_quotient"},    dif.quotient, exp_q);
        check_eq({tag, "_remainder"},   dif.remainder, exp_r);
        check_eq({tag, "_dbz"},         {31'd0, dif.div_by_zero}, {31'd0, exp_z});
    endtask

    task automatic run_one(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input logic exp_z);
        issue(s, a, b);
        wait_done(tag, 0, exp_q, exp_r, exp_z);
        @(negedge clk);
        check_eq({tag, "_done_clear"}, {31'd0, dif.done}, 32'd0);
        check_eq({tag, "_hold_q"},     dif.quotient, exp_q);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, dif.busy}, 32'd0);
        check_eq("rst_done", {31'd0, dif.done}, 32'd0);
        check_eq("rst_q",    dif.quotient, 32'd0);
        check_eq("rst_r",    dif.remainder, 32'd0);
        check_eq("rst_dbz",  {31'd0, dif.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_one("u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
        run_one("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_one("s_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
        run_one("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
        run_one("u_ovf",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        run_one("s_dz",     1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1);
        run_one("u_dz",     1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1);

        // Restart at cycle 10 must be ignored; this run also clears the zero flag.
        issue(1'b0, 32'd100, 32'd7);
        wait_done("restart", 10, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        check_eq("restart_idle", {31'd0, dif.busy}, 32'd0);

        // Back-to-back: second start presented during the done cycle.
        issue(1'b0, 32'd50, 32'd6);
        wait_done("b2b_first", 0, 32'd8, 32'd2, 1'b0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("b2b_second", 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        issue(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        dif.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, dif.busy}, 32'd0);
        check_eq("arst_done", {31'd0, dif.done}, 32'd0);
        check_eq("arst_q",    dif.quotient, 32'd0);
        check_eq("arst_r",    dif.remainder, 32'd0);
        check_eq("arst_dbz",  {31'd0, dif.div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("arst_held_done", {31'd0, dif.done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_one("post_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
